// File: rtl/bus_xfer_decoder_pkg.sv
// Shared register-code map, code type and FSM encoding for the bus transfer decoder.
package bus_xfer_decoder_pkg;

  typedef logic [4:0] code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam code_t CODE_R0  = 5'd0,  CODE_R1  = 5'd1,  CODE_R2  = 5'd2,  CODE_R3  = 5'd3;
  localparam code_t CODE_R4  = 5'd4,  CODE_R5  = 5'd5,  CODE_R6  = 5'd6,  CODE_R7  = 5'd7;
  localparam code_t CODE_R8  = 5'd8,  CODE_R9  = 5'd9,  CODE_R10 = 5'd10, CODE_R11 = 5'd11;
  localparam code_t CODE_R12 = 5'd12, CODE_R13 = 5'd13, CODE_R14 = 5'd14, CODE_R15 = 5'd15;
  localparam code_t CODE_HI  = 5'd16, CODE_LO  = 5'd17, CODE_ZHI = 5'd18, CODE_ZLO = 5'd19;
  localparam code_t CODE_PC  = 5'd20, CODE_MDR = 5'd21, CODE_INPORT = 5'd22, CODE_C = 5'd23;
  localparam code_t CODE_R24 = 5'd24, CODE_R25 = 5'd25, CODE_R26 = 5'd26, CODE_R27 = 5'd27;
  localparam code_t CODE_R28 = 5'd28, CODE_R29 = 5'd29, CODE_R30 = 5'd30, CODE_R31 = 5'd31;

  // InPort and C are read-only from the bus side, so they can never be a destination.
  function automatic logic dst_legal(code_t c);
    return !(c == CODE_INPORT || c == CODE_C);
  endfunction

endpackage

// File: rtl/bus_xfer_decoder_if.sv
// Request/enable bundle between a transfer requester and the decoder.
interface bus_xfer_decoder_if;
  import bus_xfer_decoder_pkg::*;

  logic        req;
  code_t       src_code;
  code_t       dst_code;
  logic [31:0] src_en_out;
  logic [31:0] dst_en_in;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output req, src_code, dst_code,
    input  src_en_out, dst_en_in, busy, done, err
  );

  modport slave (
    input  req, src_code, dst_code,
    output src_en_out, dst_en_in, busy, done, err
  );
endinterface

// File: rtl/bus_xfer_decoder_dec_5_32.sv
// 5-to-32 one-hot decoder with enable; all-zero output when disabled.
module dec_5_32
  import bus_xfer_decoder_pkg::*;
(
  input  code_t       code,
  input  logic        en,
  output logic [31:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end
endmodule

// File: rtl/bus_xfer_decoder.sv
// Register-transfer sequencer: drives the source for HOLD_CYCLES cycles, then
// latches into the destination for one cycle. Moore outputs off registered state.
module bus_xfer_decoder
  import bus_xfer_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic               clock,
  input  logic               clear,
  bus_xfer_decoder_if.slave  bus
);

  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

  state_t      state;
  code_t       src_q, dst_q;
  logic [3:0]  cnt;
  logic [31:0] src_oh, dst_oh;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
      src_q <= '0;
      dst_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.req) begin
          src_q <= bus.src_code;
          dst_q <= bus.dst_code;
          if (dst_legal(bus.dst_code)) begin
            state <= ST_DRIVE;
            cnt   <= HOLD_M1;
          end else begin
            state <= ST_ERR;
          end
        end
        ST_DRIVE: begin
          if (cnt == 4'd0) state <= ST_LATCH;
          else             cnt   <= cnt - 4'd1;
        end
        ST_LATCH: state <= ST_IDLE;
        ST_ERR:   state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Source stays on the bus through the latch cycle so the destination captures stable data.
  dec_5_32 u_src_dec (.code(src_q), .en(state == ST_DRIVE || state == ST_LATCH), .onehot(src_oh));
  dec_5_32 u_dst_dec (.code(dst_q), .en(state == ST_LATCH), .onehot(dst_oh));

  assign bus.src_en_out = src_oh;
  assign bus.dst_en_in  = dst_oh;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_LATCH);
  assign bus.err        = (state == ST_ERR);

endmodule

// File: tb/tb_bus_xfer_decoder.sv
// Self-checking bench: three decoders (HOLD_CYCLES 1/2/3) against a transfer-level queue model.
module tb_bus_xfer_decoder;
  import bus_xfer_decoder_pkg::*;

  logic clock;
  logic clear;
  int   checks;
  int   failures;

  bus_xfer_decoder_if b1();
  bus_xfer_decoder_if b2();
  bus_xfer_decoder_if b3();

  bus_xfer_decoder #(.HOLD_CYCLES(1)) u1 (.clock(clock), .clear(clear), .bus(b1));
  bus_xfer_decoder #(.HOLD_CYCLES(2)) u2 (.clock(clock), .clear(clear), .bus(b2));
  bus_xfer_decoder #(.HOLD_CYCLES(3)) u3 (.clock(clock), .clear(clear), .bus(b3));

  always #5 clock = ~clock;

  // Observation/expectation vectors: {src_en_out, dst_en_in, busy, done, err}
  function automatic logic [66:0] o1(); return {b1.src_en_out, b1.dst_en_in, b1.busy, b1.done, b1.err}; endfunction
  function automatic logic [66:0] o2(); return {b2.src_en_out, b2.dst_en_in, b2.busy, b2.done, b2.err}; endfunction
  function automatic logic [66:0] o3(); return {b3.src_en_out, b3.dst_en_in, b3.busy, b3.done, b3.err}; endfunction

  function automatic logic [66:0] mk(logic [31:0] s, logic [31:0] d, logic b, logic dn, logic e);
    return {s, d, b, dn, e};
  endfunction

  function automatic logic [31:0] oh(int c);
    return 32'h1 << c;
  endfunction

  localparam logic [66:0] IDLE_V = 67'h0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    b1.req = 1'b1; b1.src_code = CODE_PC; b1.dst_code = CODE_MDR;
    tick(); tick();
    checks++; if (o1() !== IDLE_V) begin failures++; $display("FAIL reset_b1 got=%h exp=%h", o1(), IDLE_V); end
    checks++; if (o2() !== IDLE_V) begin failures++; $display("FAIL reset_b2 got=%h exp=%h", o2(), IDLE_V); end
    checks++; if (o3() !== IDLE_V) begin failures++; $display("FAIL reset_b3 got=%h exp=%h", o3(), IDLE_V); end
    b1.req = 1'b0;
    clear = 1'b0;
    tick();
    checks++; if (o1() !== IDLE_V) begin failures++; $display("FAIL reset_release got=%h exp=%h", o1(), IDLE_V); end
  endtask

  task automatic test_pc_mdr();
    logic [66:0] e;
    b1.req = 1'b1; b1.src_code = CODE_PC; b1.dst_code = CODE_MDR;
    tick();
    b1.req = 1'b0;
    e = mk(32'h0010_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (o1() !== e) begin failures++; $display("FAIL pc_mdr_drive got=%h exp=%h", o1(), e); end
    tick();
    e = mk(32'h0010_0000, 32'h0020_0000, 1'b1, 1'b1, 1'b0);
    checks++; if (o1() !== e) begin failures++; $display("FAIL pc_mdr_latch got=%h exp=%h", o1(), e); end
    tick();
    checks++; if (o1() !== IDLE_V) begin failures++; $display("FAIL pc_mdr_idle got=%h exp=%h", o1(), IDLE_V); end
  endtask

  task automatic test_illegal();
    logic [66:0] e;
    e = mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int d = 22; d <= 23; d++) begin
      for (int n = 0; n < 3; n++) begin
        b1.req = 1'b1; b1.src_code = 5'($urandom_range(0, 31)); b1.dst_code = 5'(d);
        tick();
        b1.req = 1'b0;
        checks++; if (o1() !== e) begin failures++; $display("FAIL illegal_err dst=%0d got=%h exp=%h", d, o1(), e); end
        tick();
        checks++; if (o1() !== IDLE_V) begin failures++; $display("FAIL illegal_idle dst=%0d got=%h exp=%h", d, o1(), IDLE_V); end
      end
    end
  endtask

  task automatic test_hold3_ignore();
    logic [66:0] e;
    b3.req = 1'b1; b3.src_code = CODE_R31; b3.dst_code = CODE_R0;
    tick();
    e = mk(32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (o3() !== e) begin failures++; $display("FAIL hold3_drive%0d got=%h exp=%h", i, o3(), e); end
      b3.req = 1'($urandom_range(0, 1));
      b3.src_code = 5'($urandom_range(0, 31));
      b3.dst_code = 5'($urandom_range(0, 31));
      tick();
    end
    e = mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    checks++; if (o3() !== e) begin failures++; $display("FAIL hold3_latch got=%h exp=%h", o3(), e); end
    b3.req = 1'b0;
    tick();
    checks++; if (o3() !== IDLE_V) begin failures++; $display("FAIL hold3_idle got=%h exp=%h", o3(), IDLE_V); end
  endtask

  task automatic test_sweep();
    logic [66:0] e;
    for (int s = 0; s < 32; s++) begin
      for (int d = 0; d < 32; d++) begin
        if (d == 22 || d == 23) continue;
        b1.req = 1'b1; b1.src_code = 5'(s); b1.dst_code = 5'(d);
        tick();
        b1.req = 1'b0;
        tick();
        e = mk(oh(s), oh(d), 1'b1, 1'b1, 1'b0);
        checks++; if (o1() !== e) begin failures++; $display("FAIL sweep s=%0d d=%0d got=%h exp=%h", s, d, o1(), e); end
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [66:0] e;
    b2.req = 1'b1; b2.src_code = CODE_R5; b2.dst_code = CODE_R5;
    tick();
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0, 1:    e = mk(32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
        2:       e = mk(32'h20, 32'h20, 1'b1, 1'b1, 1'b0);
        default: e = IDLE_V;
      endcase
      checks++; if (o2() !== e) begin failures++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, o2(), e); end
      if (i == 15) b2.req = 1'b0;
      tick();
    end
    checks++; if (o2() !== IDLE_V) begin failures++; $display("FAIL b2b_end got=%h exp=%h", o2(), IDLE_V); end
  endtask

  task automatic test_clear_abort();
    logic [66:0] e;
    int s, d;
    s = $urandom_range(0, 31);
    d = $urandom_range(0, 21);
    b3.req = 1'b1; b3.src_code = 5'(s); b3.dst_code = 5'(d);
    tick();
    b3.req = 1'b0;
    e = mk(oh(s), 32'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (o3() !== e) begin failures++; $display("FAIL abort_drive1 got=%h exp=%h", o3(), e); end
    tick();
    checks++; if (o3() !== e) begin failures++; $display("FAIL abort_drive2 got=%h exp=%h", o3(), e); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (o3() !== IDLE_V) begin failures++; $display("FAIL abort_cleared got=%h exp=%h", o3(), IDLE_V); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (o3() !== IDLE_V) begin failures++; $display("FAIL abort_after%0d got=%h exp=%h", i, o3(), IDLE_V); end
    end
    // Abort from the latch cycle on the single-hold instance
    b1.req = 1'b1; b1.src_code = CODE_HI; b1.dst_code = CODE_LO;
    tick();
    b1.req = 1'b0;
    tick();
    e = mk(oh(16), oh(17), 1'b1, 1'b1, 1'b0);
    checks++; if (o1() !== e) begin failures++; $display("FAIL abort_latch_pre got=%h exp=%h", o1(), e); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (o1() !== IDLE_V) begin failures++; $display("FAIL abort_latch got=%h exp=%h", o1(), IDLE_V); end
  endtask

  // Transfer-level model: each accepted request expands into its list of output cycles.
  task automatic test_random();
    logic [66:0] q[$];
    logic [66:0] e;
    logic        m_idle;
    int s, d;
    logic r;
    m_idle = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 2) != 0);
      s = $urandom_range(0, 31);
      d = ($urandom_range(0, 7) == 0) ? 22 + $urandom_range(0, 1) : $urandom_range(0, 31);
      b2.req = r; b2.src_code = 5'(s); b2.dst_code = 5'(d);
      if (m_idle && r) begin
        if (d == 22 || d == 23) q.push_back(mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b1));
        else begin
          for (int h = 0; h < 2; h++) q.push_back(mk(oh(s), 32'h0, 1'b1, 1'b0, 1'b0));
          q.push_back(mk(oh(s), oh(d), 1'b1, 1'b1, 1'b0));
        end
      end
      tick();
      if (q.size() > 0) begin e = q.pop_front(); m_idle = 1'b0; end
      else begin e = IDLE_V; m_idle = 1'b1; end
      checks++; if (o2() !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, o2(), e); end
    end
    b2.req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    clock = 1'b0; clear = 1'b1; checks = 0; failures = 0;
    b1.req = 1'b0; b1.src_code = '0; b1.dst_code = '0;
    b2.req = 1'b0; b2.src_code = '0; b2.dst_code = '0;
    b3.req = 1'b0; b3.src_code = '0; b3.dst_code = '0;
    test_reset();
    test_pc_mdr();
    test_illegal();
    test_hold3_ignore();
    test_sweep();
    test_back_to_back();
    test_clear_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
